// File: rtl/fpu_pipe_arbiter_if.sv
// Bundle of requester, pipeline and response signals for fpu_pipe_arbiter.
//   slave  : arbiter side (takes requests, drives the pipeline, returns responses)
//   master : requester/pipeline side
// req*  : valid/ready request channel with operands a, b and op (0 add, 1 sub)
// pipe* : registered issue strobe and operands; pipe_result comes back from the pipeline
// rsp*  : valid/ready response channel carrying the FIFO head
interface fpu_pipe_arbiter_if;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        pipe_valid, pipe_op;
    logic [31:0] pipe_a, pipe_b, pipe_result;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output pipe_valid, pipe_a, pipe_b, pipe_op,
        input  pipe_result,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  pipe_valid, pipe_a, pipe_b, pipe_op,
        output pipe_result,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/fpu_pipe_arbiter.sv
// Shares one fixed-latency FP add/sub pipeline between two requesters.
// Round-robin issue, owner tag carried alongside each operation, results
// steered into per-requester response FIFOs. A requester is only granted
// while its FIFO occupancy plus in-flight count leaves room for the result,
// so the pipeline never stalls and nothing is dropped.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - request / pipeline / response bundle (slave modport)
//   busy - any operation in flight or any response FIFO non-empty
module fpu_pipe_arbiter #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    fpu_pipe_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int NUM_REQ = 2;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 2);

    logic [NUM_REQ-1:0]         req_valid, req_op, rsp_ready, rsp_valid;
    logic [NUM_REQ-1:0][31:0]   req_a, req_b, rsp_data;
    logic [NUM_REQ-1:0]         elig, grant, push;
    logic [NUM_REQ-1:0][CW-1:0] fifo_count;
    logic [NUM_REQ-1:0][IW-1:0] inflight;
    logic                       rr_pref;      // requester preferred on a tie
    logic [LATENCY:0]           vld_pipe;     // [0] is pipe_valid, [LATENCY] lines up with pipe_result
    logic [LATENCY:0]           id_pipe;
    logic [31:0]                pipe_a_q, pipe_b_q;
    logic                       pipe_op_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_op    = {bus.req1_op, bus.req0_op};
    assign req_a     = {bus.req1_a, bus.req0_a};
    assign req_b     = {bus.req1_b, bus.req0_b};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.pipe_valid = vld_pipe[0];
    assign bus.pipe_a     = pipe_a_q;
    assign bus.pipe_b     = pipe_b_q;
    assign bus.pipe_op    = pipe_op_q;
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_data  = rsp_data[0];
    assign bus.rsp1_data  = rsp_data[1];

    assign busy = (|inflight) | (|fifo_count);

    // Credit check and round-robin grant
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && ((32'(fifo_count[i]) + 32'(inflight[i])) < 32'(DEPTH));
        grant = '0;
        if (elig[0] && (!elig[1] || !rr_pref))
            grant[0] = 1'b1;
        else if (elig[1])
            grant[1] = 1'b1;
    end

    // Issue register and owner-tag shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            id_pipe   <= '0;
            pipe_a_q  <= '0;
            pipe_b_q  <= '0;
            pipe_op_q <= 1'b0;
            rr_pref   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-1:0], |grant};
            id_pipe  <= {id_pipe[LATENCY-1:0], grant[1]};
            if (|grant) begin
                pipe_a_q  <= grant[1] ? req_a[1]  : req_a[0];
                pipe_b_q  <= grant[1] ? req_b[1]  : req_b[0];
                pipe_op_q <= grant[1] ? req_op[1] : req_op[0];
                rr_pref   <= ~grant[1];
            end
        end
    end

    // In-flight counters: +1 on grant, -1 on retire, unchanged when both
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], push[i]})
                    2'b10:   inflight[i] <= inflight[i] + IW'(1);
                    2'b01:   inflight[i] <= inflight[i] - IW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Per-requester response FIFOs
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        logic [31:0]   mem [DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] cnt;
        logic          pop;

        assign push[g]       = vld_pipe[LATENCY] && (id_pipe[LATENCY] == 1'(g));
        assign pop           = (cnt != '0) && rsp_ready[g];
        assign fifo_count[g] = cnt;
        assign rsp_valid[g]  = (cnt != '0);
        assign rsp_data[g]   = (cnt != '0) ? mem[rd_ptr] : '0;

        always_ff @(posedge clk) begin
            if (push[g])
                mem[wr_ptr] <= bus.pipe_result;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[g])
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                case ({push[g], pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule
